instr_exec_unit: RTL and testbench
==================================

// Module: instr_exec_unit
// PURPOSE
//  Downstream consumer of instr_register: walks a range of stored instruction words via
//  read_pointer, executes opcode on operand_a/operand_b, streams results out on a
//  valid/ready handshake. Sits between the instruction register and the result checker/scoreboard.
//  Uses instr_register_pkg types (opcode_t: ZERO,PASSA,PASSB,ADD,SUB,MULT,DIV,MOD).
// PARAMETERS
//  OP_W      32  operand width (signed)
//  ADDR_W    5   register address width (32 entries)
//  RES_W     64  result width (signed), must be 2*OP_W
// PORTS
//  clk              in   1        single clock, all logic on posedge
//  reset_n          in   1        synchronous, active-low reset
//  start            in   1        begin a run; sampled only in IDLE
//  first_addr       in   ADDR_W   first register entry to execute
//  num_instr        in   ADDR_W+1 entries to execute, 0..32
//  read_pointer     out  ADDR_W   address to instr_register
//  instruction_word in   instruction_t  {opc,op_a,op_b}, combinational from read_pointer
//  res_valid        out  1        result presented
//  res_ready        in   1        consumer accepts result
//  res_data         out  RES_W    signed result
//  res_addr         out  ADDR_W   entry that produced res_data
//  res_div0         out  1        result is DIV/MOD with op_b==0
//  busy             out  1        high in any state but IDLE
//  done             out  1        one-cycle pulse at end of run
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): state=IDLE; read_pointer=0, res_valid=0, res_data=0,
//   res_addr=0, res_div0=0, busy=0, done=0, counters/divider cleared. Mid-run reset aborts,
//   result in flight discarded.
//  FSM: IDLE -> FETCH -> EXEC -> (DIVIDE) -> OUT -> FETCH | FINISH -> IDLE.
//   IDLE: on start, latch first_addr into read_pointer, remaining=num_instr. num_instr==0 ->
//    FINISH directly (done pulses, no results). Otherwise -> FETCH.
//   FETCH: capture instruction_word into internal regs (1 cycle), -> EXEC.
//   EXEC: ZERO=0; PASSA=sext(op_a); PASSB=sext(op_b); ADD/SUB=sext 65-bit-safe in RES_W;
//    MULT=full signed OP_W x OP_W -> RES_W product. These -> OUT next cycle.
//    DIV/MOD: op_b==0 -> res_data=0, res_div0=1, -> OUT. Else -> DIVIDE.
//   DIVIDE: restoring divide on magnitudes, one quotient bit/cycle, exactly OP_W cycles;
//    quotient truncates toward zero, remainder takes sign of op_a (SV / and % semantics).
//    DIV returns sext(quotient), MOD returns sext(remainder). -> OUT.
//   OUT: res_valid=1; res_data/res_addr/res_div0 held stable until res_valid&&res_ready.
//    On handshake: remaining-=1, read_pointer+=1 (wraps 31->0 mod 2^ADDR_W);
//    remaining==0 -> FINISH else FETCH. res_valid drops the cycle after handshake.
//   FINISH: done=1 for exactly one cycle, -> IDLE.
//  Latency start->first res_valid: 3 cycles non-divide, 3+OP_W cycles divide.
//  start while busy ignored; instruction_word changes after FETCH are ignored.
//  Overflow: DIV of -2^31 by -1 yields +2^31 in RES_W (no wrap, RES_W holds it).
//  res_ready may be held high permanently: one result per 3 cycles peak throughput.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles mid-DIVIDE -> all outputs 0, state IDLE, no done pulse.
//  2 first_addr=0,num=3: ADD 5,-7 / SUB 5,-7 / MULT -3,4 -> res_data -2,12,-12; addr 0,1,2; one done.
//  3 DIV -7,2 -> -3; MOD -7,2 -> -1; DIV 7,0 -> 0 with res_div0=1; divide latency = 3+32 cycles.
//  4 MULT 32'h7FFFFFFF,32'h7FFFFFFF -> 64'h3FFFFFFF00000001; DIV -2^31,-1 -> +2^31.
//  5 res_ready low 10 cycles then pulse -> res_data/res_addr stable throughout, one transfer.
//  6 first_addr=30,num=4 -> res_addr 30,31,0,1; num=0 -> done pulse, no res_valid.

Source files
------------

// File: rtl/instr_exec_unit_if.sv
// instr_exec_if: run control, instruction fetch and result handshake between
// the instruction register side and instr_exec_unit.
interface instr_exec_if #(
    parameter int OP_W   = 32,
    parameter int ADDR_W = 5,
    parameter int RES_W  = 64
);
    logic                    start;
    logic [ADDR_W-1:0]       first_addr;
    logic [ADDR_W:0]         num_instr;
    logic [ADDR_W-1:0]       read_pointer;
    logic [2*OP_W+2:0]       instruction_word;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [RES_W-1:0] res_data;
    logic [ADDR_W-1:0]       res_addr;
    logic                    res_div0;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start, first_addr, num_instr, instruction_word, res_ready,
        output read_pointer, res_valid, res_data, res_addr, res_div0, busy, done
    );
    modport master (
        output start, first_addr, num_instr, instruction_word, res_ready,
        input  read_pointer, res_valid, res_data, res_addr, res_div0, busy, done
    );
endinterface

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: walks a range of instruction register entries, executes each
// opcode (multi-cycle restoring divide for DIV/MOD) and streams results out.
package instr_register_pkg;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef struct packed {
        opcode_t            opc;
        logic signed [31:0] op_a;
        logic signed [31:0] op_b;
    } instruction_t;
endpackage

module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int OP_W   = 32,
    parameter int ADDR_W = 5,
    parameter int RES_W  = 64
) (
    input logic        clk,
    input logic        reset_n,
    instr_exec_if.slave bus
);
    localparam int CW = $clog2(OP_W);
    localparam int PW = RES_W - OP_W;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, OUT, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       rp_q, rp_d, addr_q, addr_d;
    logic [ADDR_W:0]         left_q, left_d;
    opcode_t                 opc_q, opc_d;
    logic signed [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic signed [RES_W-1:0] data_q, data_d;
    logic                    div0_q, div0_d, nq_q, nq_d, nr_q, nr_d;
    logic [OP_W-1:0]         quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    instruction_t            iw;
    logic [OP_W:0]           sh, diff;
    logic [OP_W-1:0]         quo_n, rem_n;
    logic signed [RES_W-1:0] sa, sb, alu, q_s, r_s;
    logic                    is_div;

    assign iw     = instruction_t'(bus.instruction_word);
    assign sa     = RES_W'(a_q);
    assign sb     = RES_W'(b_q);
    assign alu    = opc_q == PASSA ? sa :
                    opc_q == PASSB ? sb :
                    opc_q == ADD   ? sa + sb :
                    opc_q == SUB   ? sa - sb :
                    opc_q == MULT  ? sa * sb : '0;
    assign is_div = opc_q == DIV || opc_q == MOD;

    // One restoring step: a clear borrow bit means the divisor fit.
    assign sh    = {rem_q, quo_q[OP_W-1]};
    assign diff  = sh - {1'b0, dvs_q};
    assign quo_n = {quo_q[OP_W-2:0], ~diff[OP_W]};
    assign rem_n = diff[OP_W] ? sh[OP_W-1:0] : diff[OP_W-1:0];
    assign q_s   = nq_q ? -{{PW{1'b0}}, quo_n} : {{PW{1'b0}}, quo_n};
    assign r_s   = nr_q ? -{{PW{1'b0}}, rem_n} : {{PW{1'b0}}, rem_n};

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        addr_d  = addr_q;
        left_d  = left_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        div0_d  = div0_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                rp_d    = bus.first_addr;
                left_d  = bus.num_instr;
                state_d = bus.num_instr == '0 ? FINISH : FETCH;
            end
            FETCH: begin
                opc_d   = iw.opc;
                a_d     = iw.op_a;
                b_d     = iw.op_b;
                state_d = EXEC;
            end
            EXEC: begin
                addr_d  = rp_q;
                data_d  = alu;
                div0_d  = is_div && b_q == '0;
                state_d = is_div && b_q != '0 ? DIVIDE : OUT;
                quo_d   = a_q[OP_W-1] ? -a_q : a_q;
                dvs_d   = b_q[OP_W-1] ? -b_q : b_q;
                rem_d   = '0;
                cnt_d   = '0;
                nq_d    = a_q[OP_W-1] ^ b_q[OP_W-1];
                nr_d    = a_q[OP_W-1];
            end
            DIVIDE: begin
                quo_d = quo_n;
                rem_d = rem_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(OP_W - 1)) begin
                    data_d  = opc_q == DIV ? q_s : r_s;
                    state_d = OUT;
                end
            end
            OUT: if (bus.res_ready) begin
                left_d  = left_q - 1'b1;
                rp_d    = rp_q + 1'b1;
                state_d = left_q == (ADDR_W+1)'(1) ? FINISH : FETCH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rp_q    <= '0;
            addr_q  <= '0;
            left_q  <= '0;
            opc_q   <= ZERO;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            div0_q  <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            div0_q  <= div0_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.read_pointer = rp_q;
    assign bus.res_valid    = state_q == OUT;
    assign bus.res_data     = data_q;
    assign bus.res_addr     = addr_q;
    assign bus.res_div0     = div0_q;
    assign bus.busy         = state_q != IDLE;
    assign bus.done         = state_q == FINISH;
endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit: directed runs checked against an arithmetic reference
// model and a result queue, plus literal expectations for each scenario.
module tb_instr_exec_unit;
    localparam logic [2:0] ZERO = 3'd0, PASSA = 3'd1, PASSB = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, MULT = 3'd5, DIV = 3'd6, MOD = 3'd7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_exec_if bus ();
    instr_exec_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [66:0] mem [32];
    assign bus.instruction_word = mem[bus.read_pointer];

    longint exp_d[$], got_d[$];
    int     exp_a[$], got_a[$];
    bit     exp_z[$], got_z[$];
    int     tests = 0, fails = 0, cyc = 0, first_valid = -1, start_cyc = 0, done_cnt = 0;

    task automatic chk(string name, longint act, longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic longint model(input logic [2:0] op, input int a, input int b, output bit z);
        z = 1'b0;
        case (op)
            PASSA:   return longint'(a);
            PASSB:   return longint'(b);
            ADD:     return longint'(a) + longint'(b);
            SUB:     return longint'(a) - longint'(b);
            MULT:    return longint'(a) * longint'(b);
            DIV:     begin z = (b == 0); return z ? 0 : longint'(a) / longint'(b); end
            MOD:     begin z = (b == 0); return z ? 0 : longint'(a) % longint'(b); end
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Single compare process: every presented result must match the queue head.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_d.delete();
            exp_a.delete();
            exp_z.delete();
        end else begin
            if (bus.done) done_cnt++;
            if (bus.res_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_d.size() == 0) chk("unexpected_res_valid", 1, 0);
                else begin
                    chk("res_data", bus.res_data, exp_d[0]);
                    chk("res_addr", bus.res_addr, exp_a[0]);
                    chk("res_div0", bus.res_div0, exp_z[0]);
                    if (bus.res_ready) begin
                        got_d.push_back(bus.res_data);
                        got_a.push_back(int'(bus.res_addr));
                        got_z.push_back(bus.res_div0);
                        void'(exp_d.pop_front());
                        void'(exp_a.pop_front());
                        void'(exp_z.pop_front());
                    end
                end
            end
        end
    end

    task automatic set(int idx, logic [2:0] op, int a, int b);
        mem[idx] = {op, a, b};
    endtask

    task automatic go(int first, int num);
        int ad;
        bit z;
        for (int i = 0; i < num; i++) begin
            ad = (first + i) % 32;
            exp_d.push_back(model(mem[ad][66:64], mem[ad][63:32], mem[ad][31:0], z));
            exp_a.push_back(ad);
            exp_z.push_back(z);
        end
        first_valid    = -1;
        start_cyc      = cyc;
        bus.first_addr = first[4:0];
        bus.num_instr  = num[5:0];
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("done_timeout", longint'(bus.done), 1);
        @(posedge clk);
        #1;
        chk("queue_drained", exp_d.size(), 0);
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_read_pointer"}, bus.read_pointer, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_res_addr"}, bus.res_addr, 0);
        chk({tag, "_res_div0"}, bus.res_div0, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    initial begin
        int n0, d0, n;
        bit z;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        bus.start      = 1'b0;
        bus.first_addr = '0;
        bus.num_instr  = '0;
        bus.res_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_idle_outputs("reset");
        reset_n = 1'b1;

        chk("model_add", model(ADD, 5, -7, z), -2);
        chk("model_mod", model(MOD, -7, 2, z), -1);
        chk("model_div_ovf", model(DIV, 32'h8000_0000, -1, z), 64'sd2147483648);

        // ALU ops, back-to-back with ready held high
        set(0, ADD, 5, -7);
        set(1, SUB, 5, -7);
        set(2, MULT, -3, 4);
        n0 = got_d.size();
        d0 = done_cnt;
        go(0, 3);
        wait_done(100);
        chk("alu_latency", first_valid - start_cyc, 3);
        chk("alu_count", got_d.size() - n0, 3);
        chk("alu_done_pulses", done_cnt - d0, 1);
        if (got_d.size() - n0 == 3) begin
            chk("add_data", got_d[n0], -2);
            chk("sub_data", got_d[n0+1], 12);
            chk("mult_data", got_d[n0+2], -12);
            chk("alu_addr2", got_a[n0+2], 2);
        end

        // Divide, modulo, divide-by-zero
        set(3, DIV, -7, 2);
        set(4, MOD, -7, 2);
        set(5, DIV, 7, 0);
        n0 = got_d.size();
        go(3, 1);
        wait_done(100);
        chk("div_latency", first_valid - start_cyc, 35);
        go(4, 1);
        wait_done(100);
        chk("mod_latency", first_valid - start_cyc, 35);
        go(5, 1);
        wait_done(100);
        chk("div0_latency", first_valid - start_cyc, 3);
        chk("div_count", got_d.size() - n0, 3);
        if (got_d.size() - n0 == 3) begin
            chk("div_data", got_d[n0], -3);
            chk("mod_data", got_d[n0+1], -1);
            chk("div0_data", got_d[n0+2], 0);
            chk("div0_flag", got_z[n0+2], 1);
            chk("div_flag_clear", got_z[n0], 0);
        end

        // Extremes
        set(6, MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        set(7, DIV, 32'h8000_0000, -1);
        n0 = got_d.size();
        go(6, 2);
        wait_done(150);
        chk("ext_count", got_d.size() - n0, 2);
        if (got_d.size() - n0 == 2) begin
            chk("mult_max", got_d[n0], 64'sh3FFF_FFFF_0000_0001);
            chk("div_ovf", got_d[n0+1], 64'sh0000_0000_8000_0000);
        end

        // Wrapping address range
        set(30, PASSA, 100, 1);
        set(31, PASSB, 100, -9);
        set(0, ZERO, 55, 66);
        set(1, MOD, 17, -5);
        n0 = got_d.size();
        go(30, 4);
        wait_done(200);
        chk("wrap_count", got_d.size() - n0, 4);
        if (got_d.size() - n0 == 4) begin
            chk("wrap_addr0", got_a[n0], 30);
            chk("wrap_addr1", got_a[n0+1], 31);
            chk("wrap_addr2", got_a[n0+2], 0);
            chk("wrap_addr3", got_a[n0+3], 1);
            chk("passb_data", got_d[n0+1], -9);
            chk("mod_neg_b", got_d[n0+3], 2);
        end

        // Empty run
        n0 = got_d.size();
        d0 = done_cnt;
        go(0, 0);
        wait_done(20);
        chk("empty_no_valid", first_valid, -1);
        chk("empty_done", done_cnt - d0, 1);
        chk("empty_count", got_d.size() - n0, 0);

        // Back-pressure: result held stable until a one-cycle ready pulse
        set(8, SUB, 1000, 1);
        bus.res_ready = 1'b0;
        n0 = got_d.size();
        go(8, 1);
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_timeout", bus.res_valid, 1);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("stall_data", bus.res_data, 999);
            chk("stall_addr", bus.res_addr, 8);
            chk("stall_valid", bus.res_valid, 1);
        end
        chk("stall_no_transfer", got_d.size() - n0, 0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        wait_done(20);
        chk("stall_one_transfer", got_d.size() - n0, 1);
        bus.res_ready = 1'b1;

        // Reset in the middle of a divide
        set(9, DIV, 100, 3);
        n0 = got_d.size();
        go(9, 1);
        repeat (10) @(posedge clk);
        #1 chk("mid_div_busy", bus.busy, 1);
        reset_n = 1'b0;
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1 chk_idle_outputs("midreset");
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_no_result", got_d.size() - n0, 0);
        chk("midreset_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
